des288_capture_buf: RTL
=======================

// Module: des288_capture_buf
// PURPOSE
//   Triggered snapshot buffer downstream of the 72:288 deserializer, clocked by its divided-by-4 data clock.
//   Captures DEPTH consecutive 288-bit parallel words (32 lanes x 9 b) into on-chip storage.
//   Starts on a trigger, then streams samples out one at a time over valid/ready for scan/debug readout.
// PARAMETERS
//   LANES  32  samples per input word
//   W       9  bits per sample
//   DEPTH  16  words per capture (power of 2, >=2)
//   AW      4  log2(DEPTH)
// PORTS
//   clk         in   1         data clock (deserializer clkout_data); all logic on posedge
//   rst_n       in   1         asynchronous, active-low reset
//   din         in   LANES*W   lane k at din[9k+8:9k]
//   din_valid   in   1         din holds a new word this cycle
//   arm         in   1         1-cycle pulse: start waiting for trigger
//   trig        in   1         level; sampled only in ARMED
//   abort       in   1         1-cycle pulse: cancel any operation
//   busy        out  1         state != IDLE
//   done        out  1         1-cycle pulse after last sample accepted
//   wr_count    out  AW+1      words stored in current/last capture
//   dout        out  W         readout sample
//   dout_valid  out  1         dout valid
//   dout_last   out  1         dout is final sample (word DEPTH-1, lane LANES-1)
//   dout_ready  in   1         consumer accepts when valid&&ready
// BEHAVIOUR
//   Reset: state IDLE; all outputs 0; pointers 0; memory contents undefined.
//   FSM IDLE -> ARMED -> CAPT -> READ -> IDLE:
//   - IDLE: arm -> ARMED, wr_count <= 0. trig and din ignored.
//   - ARMED: trig && din_valid -> that same word written at addr 0, wr_count <= 1, -> CAPT.
//     trig without din_valid: no action.
//   - CAPT: each din_valid writes mem[wr_count], wr_count++. Cycles without din_valid hold.
//     Write making wr_count == DEPTH -> READ.
//   - READ: dout_valid rises the cycle after entering READ (1-cycle read latency).
//     Order word-major, lane ascending: sample n = word*LANES + lane, n = 0..DEPTH*LANES-1.
//     dout/dout_last are stable while valid && !ready. Next sample is presented on the cycle
//     after acceptance, or the same cycle if pipelined; zero-bubble streaming is required at ready=1.
//     Acceptance with dout_last -> IDLE, done=1 for one cycle, dout_valid=0.
//   - abort (any state) -> IDLE next cycle; dout_valid, dout_last := 0; no done pulse.
//     wr_count holds. abort has priority over arm, trig, and acceptance in the same cycle.
//   - arm outside IDLE is ignored. arm and abort together: abort wins.
//   - Pointers: lane index wraps LANES-1 -> 0 and advances word; no wrap past DEPTH-1.
//   - Async reset mid-capture or mid-readout: immediate return to reset values; no done.
//   - Data is opaque; no arithmetic on samples.
// STRUCTURE
//   Shared package des_pkg: LANES, W constants; typedef enum {IDLE,ARMED,CAPT,READ} cap_state_t;
//   typedef logic [W-1:0] sample_t.
//   Sub-module capture_ram: DEPTH x (LANES*W), 1 write port, 1 registered read port.
//   Behavioural model is swappable for a macro. Lane mux and output register stay in the top level.
// TESTING
//   1. Reset: pulse rst_n low mid-CAPT and mid-READ -> busy=0, dout_valid=0, done=0, state IDLE
//      next edge after release.
//   2. Basic: arm, trig at word 0, din lane k of word j = (32j+k) mod 512, ready=1 ->
//      512 samples 0..511 back-to-back, dout_last only on 511, done 1 cycle, wr_count=16.
//   3. Gapped input: din_valid every 3rd cycle during CAPT -> only valid words stored;
//      readout still 0..511.
//   4. Backpressure: dout_ready random 50% -> no drop/dup; dout/dout_last constant while stalled.
//   5. Control edges: trig in IDLE ignored; trig without din_valid in ARMED ignored;
//      arm during READ ignored; arm+abort same cycle -> stays IDLE.
//   6. Abort: abort at wr_count=7 in CAPT -> IDLE, wr_count=7, no done.
//      Abort at sample 100 in READ -> dout_valid=0 next cycle, no done. Re-arm -> wr_count=0.

Source files
------------

// File: rtl/des288_capture_buf_pkg.sv
// des288_capture_buf_pkg: shared sizes and types for the deserializer snapshot buffer
package des288_capture_buf_pkg;
  localparam int LANES = 32;
  localparam int W     = 9;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int CW    = AW + 1;
  localparam int LW    = $clog2(LANES);
  localparam int DW    = LANES * W;
  typedef enum logic [1:0] {IDLE, ARMED, CAPT, READ} cap_state_t;
  typedef logic [W-1:0] sample_t;
endpackage

// File: rtl/des288_capture_buf_if.sv
// des288_capture_buf_if: parallel word input and valid/ready sample readout
interface des288_capture_buf_if;
  logic [des288_capture_buf_pkg::DW-1:0] din;
  logic                                  din_valid;
  des288_capture_buf_pkg::sample_t       dout;
  logic                                  dout_valid;
  logic                                  dout_last;
  logic                                  dout_ready;
  modport master (output din, din_valid, dout_ready, input dout, dout_valid, dout_last);
  modport slave  (input din, din_valid, dout_ready, output dout, dout_valid, dout_last);
endinterface

// File: rtl/des288_capture_buf_capture_ram.sv
// capture_ram: DEPTH x DW storage, one write port, one registered read port
module capture_ram
  import des288_capture_buf_pkg::*;
(
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  // write on request, read every cycle so the top can steer the address for zero-bubble readout
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/des288_capture_buf.sv
// des288_capture_buf: triggered capture of DEPTH words, streamed out one sample at a time
module des288_capture_buf
  import des288_capture_buf_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                arm,
  input  logic                trig,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic [CW-1:0]       wr_count,
  des288_capture_buf_if.slave bus
);
  cap_state_t          state;
  logic [AW-1:0]       rd_word, rd_addr;
  logic [LW-1:0]       rd_lane;
  logic [DW-1:0]       rd_data;
  sample_t [LANES-1:0] rd_lanes;
  logic                dv, we, accept, last, lane_end;
  // write gating and the next read address; the address advances on the acceptance
  // of a word's final lane so the following word is already registered next cycle
  always_comb begin
    lane_end = rd_lane == LW'(LANES - 1);
    last     = rd_word == AW'(DEPTH - 1) && lane_end;
    accept   = dv && bus.dout_ready;
    we       = !abort && bus.din_valid && (state == CAPT || (state == ARMED && trig));
    rd_addr  = (accept && lane_end && !last) ? rd_word + 1'b1 : rd_word;
  end
  assign rd_lanes       = rd_data;
  assign bus.dout       = rd_lanes[rd_lane];
  assign bus.dout_valid = dv;
  assign bus.dout_last  = dv && last;
  assign busy           = state != IDLE;
  capture_ram u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr_count[AW-1:0]),
    .wdata (bus.din),
    .raddr (rd_addr),
    .rdata (rd_data)
  );
  // control FSM: arm, trigger, capture, readout; abort overrides everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wr_count <= '0;
      rd_word  <= '0;
      rd_lane  <= '0;
      dv       <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= IDLE;
        dv    <= 1'b0;
      end else begin
        case (state)
          IDLE: if (arm) begin
            state    <= ARMED;
            wr_count <= '0;
          end
          ARMED: if (trig && bus.din_valid) begin
            state    <= CAPT;
            wr_count <= CW'(1);
          end
          CAPT: if (bus.din_valid) begin
            wr_count <= wr_count + 1'b1;
            if (wr_count == CW'(DEPTH - 1)) begin
              state   <= READ;
              rd_word <= '0;
              rd_lane <= '0;
            end
          end
          READ: if (!dv) dv <= 1'b1;
          else if (bus.dout_ready) begin
            if (last) begin
              state <= IDLE;
              dv    <= 1'b0;
              done  <= 1'b1;
            end else begin
              rd_lane <= rd_lane + 1'b1;
              if (lane_end) rd_word <= rd_word + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
